// File: rtl/qpu_event_timing_queue_if.sv
// ---------------------------------------------------------------------------
// qpu_event_timing_queue_if
// Bundles the handshake buses around the event timing queue:
//   twbck_i_*  : time write-back (relative interval) from the ALU
//   ewbck_i_*  : event write-back (payload + target mask) from the ALU
//   evt_o_*    : released event strobe towards pulse generation
// master : the side that produces write-backs and consumes released events
// slave  : the queue itself
// ---------------------------------------------------------------------------
interface qpu_event_timing_queue_if #(
  parameter int TIME_W  = 32,
  parameter int EVT_W   = 64,
  parameter int EVT_NUM = 8
);
  logic               twbck_i_valid;
  logic               twbck_i_ready;
  logic [TIME_W-1:0]  twbck_i_data;
  logic               ewbck_i_valid;
  logic               ewbck_i_ready;
  logic [EVT_W-1:0]   ewbck_i_data;
  logic [EVT_NUM-1:0] ewbck_i_oprand;
  logic               evt_o_valid;
  logic [EVT_W-1:0]   evt_o_data;
  logic [EVT_NUM-1:0] evt_o_oprand;
  logic               evt_o_late;

  modport master (
    output twbck_i_valid, twbck_i_data,
    output ewbck_i_valid, ewbck_i_data, ewbck_i_oprand,
    input  twbck_i_ready, ewbck_i_ready,
    input  evt_o_valid, evt_o_data, evt_o_oprand, evt_o_late
  );

  modport slave (
    input  twbck_i_valid, twbck_i_data,
    input  ewbck_i_valid, ewbck_i_data, ewbck_i_oprand,
    output twbck_i_ready, ewbck_i_ready,
    output evt_o_valid, evt_o_data, evt_o_oprand, evt_o_late
  );
endinterface

// File: rtl/qpu_event_timing_queue.sv
// ---------------------------------------------------------------------------
// qpu_event_timing_queue
// Consumes time and event write-backs from the ALU. Each accepted interval
// advances an absolute time label; each accepted event is queued stamped with
// the current label. Once started, a free-running system timer releases the
// head entry when the timer reaches (or has passed) its timestamp.
//
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   bus        : twbck/ewbck ingress handshakes and evt_o release strobe
//   tmr_start  : pulse, IDLE -> RUN
//   flush      : pulse, drop queue, clear timer/label, return to IDLE
//   sys_timer  : current system timer value
//   q_count    : FIFO occupancy, q_empty / q_full decoded from it
// ---------------------------------------------------------------------------
module qpu_event_timing_queue #(
  parameter int  TIME_W  = 32,
  parameter int  EVT_W   = 64,
  parameter int  EVT_NUM = 8,
  parameter int  DEPTH   = 8,
  localparam int PTR_W   = $clog2(DEPTH),
  localparam int CNT_W   = PTR_W + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  qpu_event_timing_queue_if.slave bus,
  input  logic                   tmr_start,
  input  logic                   flush,
  output logic [TIME_W-1:0]      sys_timer,
  output logic [CNT_W-1:0]       q_count,
  output logic                   q_empty,
  output logic                   q_full
);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e             state_r;
  state_e             state_nxt_s;

  logic [TIME_W-1:0]  timer_r;
  logic [TIME_W-1:0]  label_r;
  logic [TIME_W-1:0]  label_nxt_s;
  logic [PTR_W-1:0]   wr_ptr_r;
  logic [PTR_W-1:0]   rd_ptr_r;
  logic [CNT_W-1:0]   count_r;

  logic [TIME_W-1:0]  ts_mem_r     [DEPTH];
  logic [EVT_W-1:0]   data_mem_r   [DEPTH];
  logic [EVT_NUM-1:0] oprand_mem_r [DEPTH];

  logic               empty_s;
  logic               full_s;
  logic               ready_s;
  logic               tw_acc_s;
  logic               push_s;
  logic [TIME_W-1:0]  head_ts_s;
  logic [TIME_W-1:0]  diff_s;
  logic               fire_s;
  logic               pop_s;

  logic               evt_valid_r;
  logic [EVT_W-1:0]   evt_data_r;
  logic [EVT_NUM-1:0] evt_oprand_r;
  logic               evt_late_r;

  assign empty_s = (count_r == {CNT_W{1'b0}});
  assign full_s  = (count_r == CNT_W'(DEPTH));

  // Ingress handshake and label arithmetic; ready depends only on the
  // registered count so a same-cycle pop never frees a slot for a push.
  always_comb begin
    ready_s     = ~full_s & ~flush;
    tw_acc_s    = bus.twbck_i_valid & ready_s;
    push_s      = bus.ewbck_i_valid & ready_s;
    label_nxt_s = label_r;
    if (tw_acc_s) begin
      label_nxt_s = label_r + bus.twbck_i_data;
    end else begin
      label_nxt_s = label_r;
    end
  end

  // Release decision: modular distance from head timestamp to timer; a clear
  // MSB means the timer is at or past the stamp within half the range.
  always_comb begin
    head_ts_s = ts_mem_r[rd_ptr_r];
    diff_s    = timer_r - head_ts_s;
    fire_s    = ~diff_s[TIME_W-1];
    pop_s     = (state_r == ST_RUN) & ~empty_s & fire_s & ~flush;
  end

  // Next-state logic; flush overrides everything else.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (tmr_start) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN:  state_nxt_s = ST_RUN;
      default: state_nxt_s = ST_IDLE;
    endcase
    if (flush) begin
      state_nxt_s = ST_IDLE;
    end else begin
      state_nxt_s = state_nxt_s;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Timer, label, pointers, occupancy and registered release outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      timer_r      <= {TIME_W{1'b0}};
      label_r      <= {TIME_W{1'b0}};
      wr_ptr_r     <= {PTR_W{1'b0}};
      rd_ptr_r     <= {PTR_W{1'b0}};
      count_r      <= {CNT_W{1'b0}};
      evt_valid_r  <= 1'b0;
      evt_data_r   <= {EVT_W{1'b0}};
      evt_oprand_r <= {EVT_NUM{1'b0}};
      evt_late_r   <= 1'b0;
    end else if (flush) begin
      // Release payload registers keep their last value; only the strobe drops.
      timer_r     <= {TIME_W{1'b0}};
      label_r     <= {TIME_W{1'b0}};
      wr_ptr_r    <= {PTR_W{1'b0}};
      rd_ptr_r    <= {PTR_W{1'b0}};
      count_r     <= {CNT_W{1'b0}};
      evt_valid_r <= 1'b0;
    end else begin
      if (state_r == ST_RUN) begin
        timer_r <= timer_r + TIME_W'(1);
      end else begin
        timer_r <= {TIME_W{1'b0}};
      end
      label_r <= label_nxt_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
      if (pop_s) begin
        evt_valid_r  <= 1'b1;
        evt_data_r   <= data_mem_r[rd_ptr_r];
        evt_oprand_r <= oprand_mem_r[rd_ptr_r];
        evt_late_r   <= (diff_s != {TIME_W{1'b0}});
      end else begin
        evt_valid_r  <= 1'b0;
      end
    end
  end

  // Entry storage; an event pushed together with an interval carries the
  // already-advanced label.
  always_ff @(posedge clk) begin
    if (!rst && push_s) begin
      ts_mem_r[wr_ptr_r]     <= label_nxt_s;
      data_mem_r[wr_ptr_r]   <= bus.ewbck_i_data;
      oprand_mem_r[wr_ptr_r] <= bus.ewbck_i_oprand;
    end
  end

  assign bus.twbck_i_ready = ready_s;
  assign bus.ewbck_i_ready = ready_s;
  assign bus.evt_o_valid   = evt_valid_r;
  assign bus.evt_o_data    = evt_data_r;
  assign bus.evt_o_oprand  = evt_oprand_r;
  assign bus.evt_o_late    = evt_late_r;

  assign sys_timer = timer_r;
  assign q_count   = count_r;
  assign q_empty   = empty_s;
  assign q_full    = full_s;

endmodule

// File: tb/tb_qpu_event_timing_queue.sv
// ---------------------------------------------------------------------------
// tb_qpu_event_timing_queue
// Directed bench: a 32-bit timer instance for ordering, late, full and flush
// scenarios, and an 8-bit timer instance for timestamp wrap-around.
// ---------------------------------------------------------------------------
module tb_qpu_event_timing_queue;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  qpu_event_timing_queue_if #(.TIME_W(32), .EVT_W(64), .EVT_NUM(8)) if32 ();
  qpu_event_timing_queue_if #(.TIME_W(8),  .EVT_W(64), .EVT_NUM(8)) if8 ();

  logic        tmr_start32, flush32, q_empty32, q_full32;
  logic [31:0] sys_timer32;
  logic [3:0]  q_count32;
  logic        tmr_start8, flush8, q_empty8, q_full8;
  logic [7:0]  sys_timer8;
  logic [3:0]  q_count8;

  qpu_event_timing_queue #(.TIME_W(32), .EVT_W(64), .EVT_NUM(8), .DEPTH(8)) dut32 (
    .clk(clk), .rst(rst), .bus(if32.slave), .tmr_start(tmr_start32), .flush(flush32),
    .sys_timer(sys_timer32), .q_count(q_count32), .q_empty(q_empty32), .q_full(q_full32)
  );

  qpu_event_timing_queue #(.TIME_W(8), .EVT_W(64), .EVT_NUM(8), .DEPTH(8)) dut8 (
    .clk(clk), .rst(rst), .bus(if8.slave), .tmr_start(tmr_start8), .flush(flush8),
    .sys_timer(sys_timer8), .q_count(q_count8), .q_empty(q_empty8), .q_full(q_full8)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        tw_v;
    logic [31:0] tw_d;
    logic        ew_v;
    logic [63:0] ew_d;
    logic [7:0]  ew_m;
    logic        start;
    logic        e_valid;
    logic [63:0] e_data;
    logic [7:0]  e_mask;
    logic        e_late;
    logic [31:0] e_timer;
    logic [3:0]  e_count;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic tw_v, input logic [31:0] tw_d, input logic ew_v,
                              input logic [63:0] ew_d, input logic [7:0] ew_m, input logic start,
                              input logic e_valid, input logic [63:0] e_data, input logic [7:0] e_mask,
                              input logic e_late, input logic [31:0] e_timer, input logic [3:0] e_count);
    vec_t v;
    v.tw_v = tw_v; v.tw_d = tw_d; v.ew_v = ew_v; v.ew_d = ew_d; v.ew_m = ew_m; v.start = start;
    v.e_valid = e_valid; v.e_data = e_data; v.e_mask = e_mask; v.e_late = e_late;
    v.e_timer = e_timer; v.e_count = e_count;
    return v;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    if32.twbck_i_valid = 1'b0; if32.twbck_i_data = 32'd0;
    if32.ewbck_i_valid = 1'b0; if32.ewbck_i_data = 64'd0; if32.ewbck_i_oprand = 8'd0;
    tmr_start32 = 1'b0; flush32 = 1'b0;
    if8.twbck_i_valid = 1'b0; if8.twbck_i_data = 8'd0;
    if8.ewbck_i_valid = 1'b0; if8.ewbck_i_data = 64'd0; if8.ewbck_i_oprand = 8'd0;
    tmr_start8 = 1'b0; flush8 = 1'b0;
  endtask

  task automatic random_inputs();
    if32.twbck_i_valid = 1'($urandom); if32.twbck_i_data = $urandom;
    if32.ewbck_i_valid = 1'($urandom); if32.ewbck_i_data = {$urandom, $urandom};
    if32.ewbck_i_oprand = 8'($urandom);
    tmr_start32 = 1'($urandom); flush32 = 1'($urandom);
    if8.twbck_i_valid = 1'($urandom); if8.twbck_i_data = 8'($urandom);
    if8.ewbck_i_valid = 1'($urandom); if8.ewbck_i_data = {$urandom, $urandom};
    if8.ewbck_i_oprand = 8'($urandom);
    tmr_start8 = 1'($urandom); flush8 = 1'($urandom);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    clear_inputs();
    step();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog");
  end

  localparam logic [63:0] EV_A = 64'hAAAA_0000_0000_000A;
  localparam logic [63:0] EV_B = 64'hBBBB_0000_0000_000B;
  localparam logic [63:0] EV_C = 64'hCCCC_0000_0000_000C;
  localparam logic [63:0] EV_D = 64'hDDDD_0000_0000_000D;

  initial begin
    bit seen;

    // Ordering/latency vectors: inputs applied for one edge, outputs checked after it.
    vecs[0]  = mk(1'b1, 32'd5, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd0,  4'd0);
    vecs[1]  = mk(1'b0, 32'd0, 1'b1, EV_A,  8'h01, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd0,  4'd1);
    vecs[2]  = mk(1'b1, 32'd3, 1'b1, EV_B,  8'h02, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd0,  4'd2);
    vecs[3]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 64'd0, 8'h00, 1'b0, 32'd0,  4'd2);
    vecs[4]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd1,  4'd2);
    vecs[5]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd2,  4'd2);
    vecs[6]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd3,  4'd2);
    vecs[7]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd4,  4'd2);
    vecs[8]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, 64'd0, 8'h00, 1'b0, 32'd5,  4'd2);
    vecs[9]  = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1, EV_A,  8'h01, 1'b0, 32'd6,  4'd1);
    vecs[10] = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, EV_A,  8'h01, 1'b0, 32'd7,  4'd1);
    vecs[11] = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, EV_A,  8'h01, 1'b0, 32'd8,  4'd1);
    vecs[12] = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b1, EV_B,  8'h02, 1'b0, 32'd9,  4'd0);
    vecs[13] = mk(1'b0, 32'd0, 1'b0, 64'd0, 8'h00, 1'b0, 1'b0, EV_B,  8'h02, 1'b0, 32'd10, 4'd0);

    // ---- Reset with random inputs ----
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      random_inputs();
      step();
    end
    rst = 1'b0;
    clear_inputs();
    #1;
    check("rst_evt_valid", 64'(if32.evt_o_valid), 64'd0);
    check("rst_evt_data", if32.evt_o_data, 64'd0);
    check("rst_evt_oprand", 64'(if32.evt_o_oprand), 64'd0);
    check("rst_evt_late", 64'(if32.evt_o_late), 64'd0);
    check("rst_sys_timer", 64'(sys_timer32), 64'd0);
    check("rst_q_count", 64'(q_count32), 64'd0);
    check("rst_q_empty", 64'(q_empty32), 64'd1);
    check("rst_q_full", 64'(q_full32), 64'd0);
    check("rst_tw_ready", 64'(if32.twbck_i_ready), 64'd1);
    check("rst_ew_ready", 64'(if32.ewbck_i_ready), 64'd1);
    check("rst_timer8", 64'(sys_timer8), 64'd0);
    check("rst_evt_valid8", 64'(if8.evt_o_valid), 64'd0);

    // ---- Ordering and latency (table-driven) ----
    do_reset();
    for (int i = 0; i < 14; i++) begin
      if32.twbck_i_valid = vecs[i].tw_v; if32.twbck_i_data = vecs[i].tw_d;
      if32.ewbck_i_valid = vecs[i].ew_v; if32.ewbck_i_data = vecs[i].ew_d;
      if32.ewbck_i_oprand = vecs[i].ew_m; tmr_start32 = vecs[i].start;
      step();
      check($sformatf("ord[%0d].valid", i), 64'(if32.evt_o_valid), 64'(vecs[i].e_valid));
      check($sformatf("ord[%0d].data", i), if32.evt_o_data, vecs[i].e_data);
      check($sformatf("ord[%0d].oprand", i), 64'(if32.evt_o_oprand), 64'(vecs[i].e_mask));
      check($sformatf("ord[%0d].late", i), 64'(if32.evt_o_late), 64'(vecs[i].e_late));
      check($sformatf("ord[%0d].timer", i), 64'(sys_timer32), 64'(vecs[i].e_timer));
      check($sformatf("ord[%0d].count", i), 64'(q_count32), 64'(vecs[i].e_count));
      check($sformatf("ord[%0d].ready", i), 64'(if32.ewbck_i_ready), 64'd1);
    end
    clear_inputs();
    check("ord_empty", 64'(q_empty32), 64'd1);

    // ---- Late event: label 10, push at sys_timer 20 ----
    do_reset();
    if32.twbck_i_valid = 1'b1; if32.twbck_i_data = 32'd10;
    step();
    clear_inputs();
    tmr_start32 = 1'b1;
    step();
    clear_inputs();
    for (int k = 0; k < 100 && sys_timer32 != 32'd20; k++) step();
    check("late_reach_20", 64'(sys_timer32), 64'd20);
    if32.ewbck_i_valid = 1'b1; if32.ewbck_i_data = EV_C; if32.ewbck_i_oprand = 8'h04;
    step();
    clear_inputs();
    check("late_not_yet", 64'(if32.evt_o_valid), 64'd0);
    step();
    check("late_valid", 64'(if32.evt_o_valid), 64'd1);
    check("late_data", if32.evt_o_data, EV_C);
    check("late_oprand", 64'(if32.evt_o_oprand), 64'h04);
    check("late_flag", 64'(if32.evt_o_late), 64'd1);
    check("late_timer", 64'(sys_timer32), 64'd22);

    // ---- Full: 9 events with ts 0..8 pushed in IDLE ----
    do_reset();
    for (int i = 0; i < 8; i++) begin
      if32.twbck_i_valid = (i != 0); if32.twbck_i_data = 32'd1;
      if32.ewbck_i_valid = 1'b1; if32.ewbck_i_data = 64'h100 + 64'(i);
      if32.ewbck_i_oprand = 8'(i);
      step();
    end
    check("full_flag", 64'(q_full32), 64'd1);
    check("full_count", 64'(q_count32), 64'd8);
    if32.twbck_i_valid = 1'b1; if32.twbck_i_data = 32'd1;
    if32.ewbck_i_valid = 1'b1; if32.ewbck_i_data = 64'h108; if32.ewbck_i_oprand = 8'hFF;
    #1;
    check("full_ew_ready", 64'(if32.ewbck_i_ready), 64'd0);
    check("full_tw_ready", 64'(if32.twbck_i_ready), 64'd0);
    tmr_start32 = 1'b1;
    step();
    tmr_start32 = 1'b0;
    check("full_held_count", 64'(q_count32), 64'd8);
    check("full_start_timer", 64'(sys_timer32), 64'd0);
    check("full_still_not_ready", 64'(if32.ewbck_i_ready), 64'd0);
    step();
    check("full_pop0_valid", 64'(if32.evt_o_valid), 64'd1);
    check("full_pop0_data", if32.evt_o_data, 64'h100);
    check("full_pop0_timer", 64'(sys_timer32), 64'd1);
    check("full_pop0_count", 64'(q_count32), 64'd7);
    check("full_ready_after_pop", 64'(if32.ewbck_i_ready), 64'd1);
    step();
    clear_inputs();
    check("full_pop1_valid", 64'(if32.evt_o_valid), 64'd1);
    check("full_pop1_data", if32.evt_o_data, 64'h101);
    check("full_pushpop_count", 64'(q_count32), 64'd7);
    for (int k = 2; k <= 8; k++) begin
      step();
      check($sformatf("full_rel[%0d].valid", k), 64'(if32.evt_o_valid), 64'd1);
      check($sformatf("full_rel[%0d].data", k), if32.evt_o_data, 64'h100 + 64'(k));
      check($sformatf("full_rel[%0d].timer", k), 64'(sys_timer32), 64'(k + 1));
      check($sformatf("full_rel[%0d].late", k), 64'(if32.evt_o_late), 64'd0);
    end
    check("full_drained", 64'(q_empty32), 64'd1);

    // ---- Flush mid-run ----
    do_reset();
    if32.twbck_i_valid = 1'b1; if32.twbck_i_data = 32'd100;
    for (int i = 0; i < 4; i++) begin
      if32.ewbck_i_valid = 1'b1; if32.ewbck_i_data = 64'hE0 + 64'(i);
      step();
      if32.twbck_i_valid = 1'b0;
    end
    clear_inputs();
    check("flush_count4", 64'(q_count32), 64'd4);
    tmr_start32 = 1'b1;
    step();
    clear_inputs();
    for (int k = 0; k < 100 && sys_timer32 != 32'd7; k++) step();
    check("flush_reach_7", 64'(sys_timer32), 64'd7);
    flush32 = 1'b1; tmr_start32 = 1'b1;
    if32.ewbck_i_valid = 1'b1; if32.ewbck_i_data = 64'hEE;
    #1;
    check("flush_ew_ready", 64'(if32.ewbck_i_ready), 64'd0);
    step();
    clear_inputs();
    check("flush_timer", 64'(sys_timer32), 64'd0);
    check("flush_count", 64'(q_count32), 64'd0);
    check("flush_valid", 64'(if32.evt_o_valid), 64'd0);
    for (int k = 0; k < 4; k++) begin
      step();
      check($sformatf("flush_idle[%0d].timer", k), 64'(sys_timer32), 64'd0);
      check($sformatf("flush_idle[%0d].valid", k), 64'(if32.evt_o_valid), 64'd0);
      check($sformatf("flush_idle[%0d].count", k), 64'(q_count32), 64'd0);
    end

    // ---- Wrap with an 8-bit timer ----
    do_reset();
    if8.twbck_i_valid = 1'b1; if8.twbck_i_data = 8'd250;
    step();
    clear_inputs();
    tmr_start8 = 1'b1;
    step();
    clear_inputs();
    for (int k = 0; k < 400 && sys_timer8 != 8'd250; k++) step();
    check("wrap_reach_250", 64'(sys_timer8), 64'd250);
    if8.twbck_i_valid = 1'b1; if8.twbck_i_data = 8'd10;
    if8.ewbck_i_valid = 1'b1; if8.ewbck_i_data = EV_D; if8.ewbck_i_oprand = 8'h08;
    step();
    clear_inputs();
    check("wrap_count", 64'(q_count8), 64'd1);
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin
      step();
      if (if8.evt_o_valid) begin
        seen = 1'b1;
        check("wrap_rel_timer", 64'(sys_timer8), 64'd5);
        check("wrap_rel_data", if8.evt_o_data, EV_D);
        check("wrap_rel_late", 64'(if8.evt_o_late), 64'd0);
      end
    end
    check("wrap_seen", 64'(seen), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/qpu_event_timing_queue.md
Name: qpu_event_timing_queue

Overview:
- Consumer end of the ALU time write-back (twbck) and event write-back (ewbck) interfaces.
- Each accepted twbck interval (QWAIT/ntp) advances an absolute time label.
- Each accepted ewbck (QI) is pushed into a FIFO stamped with the current label.
- Once the timeline is started, a free-running system timer releases each head entry to the pulse-generation side when the timer reaches its timestamp.

Parameters:
- TIME_W, 32, width of time label, interval and system timer (matches QPU_TIME_WIDTH).
- EVT_W, 64, event wire width (matches QPU_EVENT_WIRE_WIDTH).
- EVT_NUM, 8, event operand mask width (matches QPU_EVENT_NUM).
- DEPTH, 8, FIFO entries; power of two, at least 2.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous, active-high reset.
- twbck_i_valid  in  1  time interval valid.
- twbck_i_ready  out  1  time interval accepted.
- twbck_i_data  in  TIME_W  relative interval.
- ewbck_i_valid  in  1  event valid.
- ewbck_i_ready  out  1  event accepted.
- ewbck_i_data  in  EVT_W  event payload.
- ewbck_i_oprand  in  EVT_NUM  event target mask.
- tmr_start  in  1  pulse: start the timeline.
- flush  in  1  pulse: discard queue and return to IDLE.
- evt_o_valid  out  1  one-cycle event strobe; no backpressure.
- evt_o_data  out  EVT_W  released payload.
- evt_o_oprand  out  EVT_NUM  released mask.
- evt_o_late  out  1  released entry's timestamp had already passed.
- sys_timer  out  TIME_W  current system timer.
- q_count  out  clog2(DEPTH)+1  FIFO occupancy.
- q_empty  out  1  q_count==0.
- q_full  out  1  q_count==DEPTH.

Behaviour:
- Reset (rst=1 at clk edge):
  - state=IDLE; sys_timer, time label, pointers and q_count all 0.
  - evt_o_valid, evt_o_data, evt_o_oprand and evt_o_late all 0.
- States:
  - IDLE: timer held at 0; no release.
  - RUN: timer increments by 1 every cycle, wrapping mod 2^TIME_W.
  - IDLE->RUN on tmr_start. tmr_start while in RUN is ignored.
  - Either state -> IDLE on flush; flush has priority over tmr_start and over any push or pop in the same cycle.
- Flush: clears timer, label, pointers and count; evt_o_valid=0 next cycle; inputs presented in that cycle are not accepted.
- Ready:
  - twbck_i_ready = ewbck_i_ready = ~q_full & ~flush.
  - Both are computed from the registered count, so a pop in the same cycle does not free a slot for a push.
- Ingress, evaluated per accepted handshake:
  - twbck only: label <= label + twbck_i_data (mod 2^TIME_W).
  - ewbck only: push {label, data, oprand}.
  - Both in the same cycle: label updates first; the pushed entry carries label + twbck_i_data, and label takes that value.
- Release decision (RUN only, head present):
  - diff = sys_timer - head.ts, mod 2^TIME_W.
  - fire = ~diff[TIME_W-1], i.e. the timer is at or ahead of ts within half range.
  - On fire, at the next edge: pop head; evt_o_valid=1; evt_o_data and evt_o_oprand = head fields; evt_o_late = (diff != 0).
  - Otherwise evt_o_valid=0 and data/oprand/late hold their previous values.
- Rate and latency:
  - At most one release per cycle.
  - An entry with ts=T pushed well in advance produces evt_o_valid in the cycle where sys_timer==T+1.
  - An entry pushed late is released at the earliest 2 cycles after its push edge: one cycle to become head, one registered output stage.
  - Entries sharing a timestamp release on consecutive cycles in FIFO order; the second and later ones are flagged late.
- Push and pop in the same cycle: q_count unchanged; pointers wrap mod DEPTH.
- Entries pushed in IDLE stay queued until RUN.
- sys_timer is the registered counter value.

Test Plan:
- Reset: drive rst for 2 cycles with random inputs -> all outputs 0, q_empty=1, both readys=1 on the first cycle after reset.
- Ordering and latency:
  - Stimulus: twbck 5; ewbck A/0x01; twbck 3 together with ewbck B/0x02; then tmr_start.
  - Response: A released when sys_timer==6 with late=0; B released when sys_timer==9 with late=0; q_empty afterwards.
- Late event: in RUN at sys_timer==20 with label 10, push C -> evt_o_valid two cycles after the push edge with data C and evt_o_late=1.
- Full:
  - Stimulus: DEPTH=8; push 9 events in IDLE, each with ts 0..8.
  - Response: q_full after 8 pushes, 9th held with ready=0. After tmr_start, first release at sys_timer==1; ready=1 the cycle after the pop; 9th accepted.
- Flush mid-run: 4 entries queued, sys_timer==7, flush together with ewbck_i_valid -> next cycle sys_timer==0, state IDLE, q_count==0, no event accepted, no evt_o_valid afterwards.
- Wrap:
  - Stimulus: TIME_W=8; label set to 250 via twbck; start; hold until sys_timer==250; then twbck 10 plus ewbck D.
  - Response: D (ts=4) is not released at 250..255; it is released when sys_timer==5 after wrapping, with late=0.
